// File: rtl/jtag_pkg.sv
// ---------------------------------------------------------------------------
// jtag_pkg
// Shared types and constants for the JTAG master:
//   jtag_op_e    - command opcodes accepted on cmd_op
//   jtag_state_e - master FSM states
//   IR_*         - 3-bit instruction codes of the target TAP, IR_LEN = 3
//   pre_len()    - number of TCK cycles in the TMS preamble of a command
//   pre_tms()    - TMS value for a given preamble step
// ---------------------------------------------------------------------------
package jtag_pkg;

  localparam int LEN_W  = 6;
  localparam int IR_LEN = 3;

  localparam logic [IR_LEN-1:0] IR_BYPASS  = 3'b111;
  localparam logic [IR_LEN-1:0] IR_IDCODE  = 3'b001;
  localparam logic [IR_LEN-1:0] IR_SAMPLE  = 3'b010;
  localparam logic [IR_LEN-1:0] IR_PRELOAD = 3'b011;
  localparam logic [IR_LEN-1:0] IR_INTEST  = 3'b100;
  localparam logic [IR_LEN-1:0] IR_EXTEST  = 3'b101;

  typedef enum logic [1:0] {
    OP_RESET = 2'd0,
    OP_IR    = 2'd1,
    OP_DR    = 2'd2,
    OP_IDLE  = 2'd3
  } jtag_op_e;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PRE   = 3'd1,
    S_SHIFT = 3'd2,
    S_POST  = 3'd3,
    S_RSP   = 3'd4
  } jtag_state_e;

  // OP_IDLE is modelled as a preamble of cmd_len cycles with TMS=0, so the
  // same step counter serves every opcode.
  function automatic logic [LEN_W-1:0] pre_len(jtag_op_e op, logic [LEN_W-1:0] len);
    logic [LEN_W-1:0] r;
    case (op)
      OP_RESET: r = 6'd6;
      OP_IR:    r = 6'd4;
      OP_DR:    r = 6'd3;
      default:  r = len;
    endcase
    return r;
  endfunction

  // RESET: 1,1,1,1,1,0   IR: 1,1,0,0   DR: 1,0,0   IDLE: all 0
  function automatic logic pre_tms(jtag_op_e op, logic [LEN_W-1:0] step);
    logic r;
    case (op)
      OP_RESET: r = (step < 6'd5);
      OP_IR:    r = (step < 6'd2);
      OP_DR:    r = (step == 6'd0);
      default:  r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/jtag_tck_gen.sv
// ---------------------------------------------------------------------------
// jtag_tck_gen
// TCK divider: while en is high, tck toggles every CLK_DIV clk cycles,
// starting low; while en is low tck is held low and the divider is cleared.
// Ports:
//   clk, rst   - system clock, synchronous active-high reset
//   en         - run the divider
//   tck        - divided clock (registered)
//   rise, fall - one-cycle strobes, high in the clk cycle whose closing edge
//                drives tck high (rise) or low (fall)
// ---------------------------------------------------------------------------
module jtag_tck_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tck,
  output logic rise,
  output logic fall
);

  logic [7:0] cnt_reg;
  logic       tck_reg;
  logic       toggle;

  assign toggle = en && (cnt_reg == 8'(CLK_DIV - 1));
  assign rise   = toggle && !tck_reg;
  assign fall   = toggle && tck_reg;
  assign tck    = tck_reg;

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      cnt_reg <= '0;
      tck_reg <= 1'b0;
    end else if (toggle) begin
      cnt_reg <= '0;
      tck_reg <= ~tck_reg;
    end else begin
      cnt_reg <= cnt_reg + 8'd1;
    end
  end

endmodule

// File: rtl/jtag_master.sv
// ---------------------------------------------------------------------------
// jtag_master
// Command-driven JTAG master. Each accepted command drives a TMS/TDI
// sequence on tck/tms/tdi, captures tdo during shift cycles and returns one
// response (rsp_data, rsp_err) held until rsp_ready.
// Parameters: CLK_DIV (clk cycles per TCK half period, 2..255),
//             MAX_LEN (maximum shift length in bits).
// Ports:
//   clk, rst                      - clock, synchronous active-high reset
//   cmd_valid/cmd_ready           - command handshake
//   cmd_op, cmd_len, cmd_data     - opcode, bit/cycle count, TDI bits (LSB first)
//   rsp_valid/rsp_ready           - response handshake
//   rsp_data, rsp_err             - captured TDO bits, command rejected
//   busy                          - command executing
//   tck, tms, tdi, tdo            - JTAG pins
// Build option: define JTAG_MASTER_TDO_SYNC_EN to pass tdo through a 2-flop
// synchronizer; the sample then lands two clk cycles after the tck rise and
// CLK_DIV must be at least 3.
// ---------------------------------------------------------------------------
module jtag_master
  import jtag_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int MAX_LEN = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  jtag_op_e           cmd_op,
  input  logic [5:0]         cmd_len,
  input  logic [MAX_LEN-1:0] cmd_data,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [MAX_LEN-1:0] rsp_data,
  output logic               rsp_err,
  output logic               busy,
  output logic               tck,
  output logic               tms,
  output logic               tdi,
  input  logic               tdo
);

  localparam logic [LEN_W:0] MAX_LEN_W = (LEN_W + 1)'(MAX_LEN);

  jtag_state_e        state_reg, state_next;
  jtag_op_e           op_reg, op_next;
  logic [LEN_W-1:0]   len_reg, len_next;
  logic [MAX_LEN-1:0] data_reg, data_next;
  logic [LEN_W-1:0]   step_reg, step_next;
  logic [LEN_W-1:0]   bit_reg, bit_next;
  logic               tms_reg, tms_next;
  logic               tdi_reg, tdi_next;
  logic [MAX_LEN-1:0] rsp_data_reg, rsp_data_next;
  logic               rsp_err_reg, rsp_err_next;

  logic               tck_rise, tck_fall;
  logic               cap_strobe;
  logic [LEN_W-1:0]   cap_idx;
  logic               cap_bit;
  logic [LEN_W-1:0]   step_inc, bit_inc;
  logic               len_bad;

  assign busy      = (state_reg == S_PRE) || (state_reg == S_SHIFT) || (state_reg == S_POST);
  assign cmd_ready = (state_reg == S_IDLE) && !rst;
  assign rsp_valid = (state_reg == S_RSP);
  assign rsp_data  = rsp_data_reg;
  assign rsp_err   = rsp_err_reg;
  assign tms       = tms_reg;
  assign tdi       = tdi_reg;

  assign step_inc  = step_reg + 6'd1;
  assign bit_inc   = bit_reg + 6'd1;
  assign len_bad   = (cmd_len == '0) || ({1'b0, cmd_len} > MAX_LEN_W);

  jtag_tck_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tck_gen (
    .clk  (clk),
    .rst  (rst),
    .en   (busy),
    .tck  (tck),
    .rise (tck_rise),
    .fall (tck_fall)
  );

`ifdef JTAG_MASTER_TDO_SYNC_EN
  // The bit index and capture strobe travel alongside tdo through the
  // synchronizer, so the sample taken two cycles later is the tdo value that
  // was present at the tck rise.
  logic             tdo_s1_reg, tdo_s2_reg;
  logic             cap_p1_reg, cap_p2_reg;
  logic [LEN_W-1:0] idx_p1_reg, idx_p2_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      tdo_s1_reg <= 1'b0;
      tdo_s2_reg <= 1'b0;
      cap_p1_reg <= 1'b0;
      cap_p2_reg <= 1'b0;
      idx_p1_reg <= '0;
      idx_p2_reg <= '0;
    end else begin
      tdo_s1_reg <= tdo;
      tdo_s2_reg <= tdo_s1_reg;
      cap_p1_reg <= tck_rise && (state_reg == S_SHIFT);
      cap_p2_reg <= cap_p1_reg;
      idx_p1_reg <= bit_reg;
      idx_p2_reg <= idx_p1_reg;
    end
  end

  assign cap_strobe = cap_p2_reg;
  assign cap_idx    = idx_p2_reg;
  assign cap_bit    = tdo_s2_reg;
`else
  assign cap_strobe = tck_rise && (state_reg == S_SHIFT);
  assign cap_idx    = bit_reg;
  assign cap_bit    = tdo;
`endif

  // tms/tdi hold the values for the TCK cycle in progress; they are loaded on
  // acceptance and then only on a falling-edge strobe, which also advances
  // the sequence to the next TCK cycle.
  always_comb begin
    state_next    = state_reg;
    op_next       = op_reg;
    len_next      = len_reg;
    data_next     = data_reg;
    step_next     = step_reg;
    bit_next      = bit_reg;
    tms_next      = tms_reg;
    tdi_next      = tdi_reg;
    rsp_data_next = rsp_data_reg;
    rsp_err_next  = rsp_err_reg;

    case (state_reg)
      S_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          op_next       = cmd_op;
          len_next      = cmd_len;
          data_next     = cmd_data;
          step_next     = '0;
          bit_next      = '0;
          tdi_next      = 1'b0;
          rsp_data_next = '0;
          rsp_err_next  = 1'b0;
          if ((cmd_op != OP_RESET) && len_bad) begin
            rsp_err_next = 1'b1;
            state_next   = S_RSP;
          end else begin
            tms_next   = pre_tms(cmd_op, 6'd0);
            state_next = S_PRE;
          end
        end
      end

      S_PRE: begin
        if (tck_fall) begin
          if (step_inc < pre_len(op_reg, len_reg)) begin
            step_next = step_inc;
            tms_next  = pre_tms(op_reg, step_inc);
          end else if ((op_reg == OP_IR) || (op_reg == OP_DR)) begin
            state_next = S_SHIFT;
            bit_next   = '0;
            tms_next   = (len_reg == 6'd1);
            tdi_next   = data_reg[0];
            data_next  = data_reg >> 1;
          end else begin
            state_next = S_RSP;
            tdi_next   = 1'b0;
          end
        end
      end

      S_SHIFT: begin
        if (tck_fall) begin
          if (bit_inc < len_reg) begin
            bit_next  = bit_inc;
            // TMS=1 on the last shift bit moves the TAP to Exit1
            tms_next  = (bit_inc == (len_reg - 6'd1));
            tdi_next  = data_reg[0];
            data_next = data_reg >> 1;
          end else begin
            state_next = S_POST;
            step_next  = '0;
            tms_next   = 1'b1;
            tdi_next   = 1'b0;
          end
        end
      end

      S_POST: begin
        if (tck_fall) begin
          if (step_reg == 6'd0) begin
            step_next = 6'd1;
            tms_next  = 1'b0;
          end else begin
            state_next = S_RSP;
          end
        end
      end

      S_RSP: begin
        if (rsp_ready) begin
          state_next = S_IDLE;
        end
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase

    if (cap_strobe) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        if (cap_idx == LEN_W'(i)) begin
          rsp_data_next[i] = cap_bit;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      op_reg       <= OP_RESET;
      len_reg      <= '0;
      data_reg     <= '0;
      step_reg     <= '0;
      bit_reg      <= '0;
      tms_reg      <= 1'b1;
      tdi_reg      <= 1'b0;
      rsp_data_reg <= '0;
      rsp_err_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      op_reg       <= op_next;
      len_reg      <= len_next;
      data_reg     <= data_next;
      step_reg     <= step_next;
      bit_reg      <= bit_next;
      tms_reg      <= tms_next;
      tdi_reg      <= tdi_next;
      rsp_data_reg <= rsp_data_next;
      rsp_err_reg  <= rsp_err_next;
    end
  end

endmodule
